// File: rtl/uart_tx_parity.sv
// uart_tx_parity: UART transmitter, start / DBIT data (LSB first) / parity / stop, paced by a 16x s_tick.
// Define UART_TX_PARITY_EN to include the parity bit; otherwise frames omit it and tx_parity reads 0.
module uart_tx_parity #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx_parity,
    output logic            tx
);
    localparam int SW = ($clog2(SB_TICK) < 4) ? 4 : $clog2(SB_TICK);
    localparam int NW = (DBIT < 2) ? 1 : $clog2(DBIT);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            bit_end;
    assign bit_end = s_tick && (s_q == SW'(15));
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        tx_done_tick = 1'b0;
        case (state_q)
            IDLE: if (tx_start) begin
                state_d = START;
                b_d     = din;
                s_d     = '0;
            end
            START: if (s_tick) begin
                s_d = bit_end ? '0 : s_q + SW'(1);
                n_d = bit_end ? '0 : n_q;
                state_d = bit_end ? DATA : START;
            end
            DATA: if (s_tick) begin
                s_d = bit_end ? '0 : s_q + SW'(1);
                if (bit_end) begin
                    b_d = b_q >> 1;
                    n_d = (n_q == NW'(DBIT - 1)) ? n_q : n_q + NW'(1);
`ifdef UART_TX_PARITY_EN
                    state_d = (n_q == NW'(DBIT - 1)) ? PARITY : DATA;
`else
                    state_d = (n_q == NW'(DBIT - 1)) ? STOP : DATA;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (s_tick) begin
                s_d     = bit_end ? '0 : s_q + SW'(1);
                state_d = bit_end ? STOP : PARITY;
            end
`endif
            STOP: if (s_tick) begin
                // Stop length is SB_TICK ticks, so the terminal count differs from the 16-tick bits
                if (s_q == SW'(SB_TICK - 1)) begin
                    s_d          = '0;
                    state_d      = IDLE;
                    tx_done_tick = 1'b1;
                end else begin
                    s_d = s_q + SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
`ifdef UART_TX_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
    logic p_q, p_d;
    assign p_d  = (state_q == IDLE && tx_start) ? ((^din) ^ ODD) : p_q;
    assign tx_d = (state_d == START)  ? 1'b0 :
                  (state_d == DATA)   ? b_d[0] :
                  (state_d == PARITY) ? p_d : 1'b1;
    always_ff @(posedge clk) begin
        if (reset) p_q <= 1'b0;
        else       p_q <= p_d;
    end
    assign tx_parity = p_q;
`else
    logic unused_odd;
    assign unused_odd = (PARITY_ODD != 0);
    assign tx_d = (state_d == START) ? 1'b0 :
                  (state_d == DATA)  ? b_d[0] : 1'b1;
    assign tx_parity = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end
    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_parity.sv
// tb_uart_tx_parity: randomized bench comparing two uart_tx_parity instances (even/16-tick stop, odd/24-tick stop)
// against a frame-as-bit-list reference model.
module tb_uart_tx_parity;
`ifdef UART_TX_PARITY_EN
    localparam bit EN    = 1'b1;
    localparam int NBITS = 11;
`else
    localparam bit EN    = 1'b0;
    localparam int NBITS = 10;
`endif
    localparam int ODD [2] = '{0, 1};
    localparam int SBT [2] = '{16, 24};
    logic       clk = 1'b0;
    logic       reset, s_tick, tx_start;
    logic [7:0] din;
    logic [1:0] tx_w, busy_w, done_w, par_w;
    int passed = 0, total = 0;
    bit m_busy [2];
    int m_idx [2], m_cnt [2];
    bit m_bits [2][12];
    int m_dur [2][12];
    bit m_par [2];
    int dcnt [2], bobs [2];
    always #5 clk = ~clk;
    uart_tx_parity #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
        .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]), .tx_parity(par_w[0]), .tx(tx_w[0]));
    uart_tx_parity #(.DBIT(8), .SB_TICK(24), .PARITY_ODD(1)) dut1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
        .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]), .tx_parity(par_w[1]), .tx(tx_w[1]));
    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask
    // A frame is a list of line levels, each held for a number of ticks
    function automatic void load(input int k, input logic [7:0] d);
        m_bits[k][0] = 1'b0;
        m_dur[k][0]  = 16;
        for (int i = 0; i < 8; i++) begin
            m_bits[k][1+i] = d[i];
            m_dur[k][1+i]  = 16;
        end
        m_par[k] = EN ? ((^d) ^ (ODD[k] != 0)) : 1'b0;
        if (EN) begin
            m_bits[k][9] = m_par[k];
            m_dur[k][9]  = 16;
        end
        m_bits[k][NBITS-1] = 1'b1;
        m_dur[k][NBITS-1]  = SBT[k];
        m_busy[k] = 1'b1;
        m_idx[k]  = 0;
        m_cnt[k]  = 0;
    endfunction
    task automatic step(input bit rst, input bit st, input bit tk);
        bit ed;
        @(negedge clk);
        reset = rst; tx_start = st; s_tick = tk;
        #1;
        for (int k = 0; k < 2; k++) begin
            ed = m_busy[k] && tk && m_idx[k] == NBITS-1 && m_cnt[k] == m_dur[k][NBITS-1]-1;
            if (!rst) check($sformatf("done%0d", k), done_w[k], ed);
            dcnt[k] += int'(done_w[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] = 1'b0;
                m_par[k]  = 1'b0;
            end else if (!m_busy[k]) begin
                if (st) load(k, din);
            end else if (tk) begin
                m_cnt[k]++;
                if (m_cnt[k] == m_dur[k][m_idx[k]]) begin
                    m_cnt[k] = 0;
                    m_idx[k]++;
                    if (m_idx[k] == NBITS) m_busy[k] = 1'b0;
                end
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("tx%0d", k), tx_w[k], m_busy[k] ? m_bits[k][m_idx[k]] : 1'b1);
            check($sformatf("busy%0d", k), busy_w[k], m_busy[k]);
            check($sformatf("par%0d", k), par_w[k], m_par[k]);
            bobs[k] += int'(busy_w[k]);
        end
    endtask
    task automatic clear_counts();
        dcnt = '{0, 0};
        bobs = '{0, 0};
    endtask
    // per = 0 gives random ticks; poke >= 0 fires an ignored tx_start with din = 0xFF mid-frame
    task automatic frame(input logic [7:0] d, input int per, input int poke);
        int c;
        bit tk;
        clear_counts();
        din = d;
        step(1'b0, 1'b1, 1'b1);
        c = 0;
        while (busy_w != 2'b00 && c < 3000) begin
            tk = (per == 0) ? ($urandom_range(0, 2) == 0) : (c % per == per - 1);
            if (c == poke) begin
                din = 8'hFF;
                step(1'b0, 1'b1, tk);
            end else begin
                step(1'b0, 1'b0, tk);
            end
            c++;
        end
        check("frame_end", busy_w, 0);
        check("done_cnt0", dcnt[0], 1);
        check("done_cnt1", dcnt[1], 1);
    endtask
    initial begin
        int c, cd, gap;
        reset = 1'b1; tx_start = 1'b0; s_tick = 1'b0; din = 8'h00;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        clear_counts();
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1);
        check("idle_done", dcnt[0] + dcnt[1], 0);
        check("idle_tx", tx_w, 2'b11);
        frame(8'h55, 1, -1);
        check("busy_len0", bobs[0], 16 * (NBITS - 1) + 16);
        check("busy_len1", bobs[1], 16 * (NBITS - 1) + 24);
        check("par55_0", par_w[0], 0);
        check("par55_1", par_w[1], EN ? 1 : 0);
        frame(8'h07, 1, -1);
        check("par07_0", par_w[0], EN ? 1 : 0);
        check("par07_1", par_w[1], 0);
        frame(8'hA3, 4, 100);
        check("parA3_0", par_w[0], 0);
        check("parA3_1", par_w[1], EN ? 1 : 0);
        clear_counts();
        din = 8'h01; c = 0; cd = -1; gap = -1;
        while (dcnt[0] < 2 && c < 2000) begin
            step(1'b0, 1'b1, 1'b1);
            if (dcnt[0] == 1 && cd < 0) begin
                cd = c;
                din = 8'h80;
            end else if (cd >= 0 && gap < 0 && tx_w[0] == 1'b0) begin
                gap = c - cd;
            end
            c++;
        end
        check("b2b_done", dcnt[0], 2);
        check("b2b_gap", gap, 1);
        c = 0;
        while (busy_w != 2'b00 && c < 1000) begin
            step(1'b0, 1'b0, 1'b1);
            c++;
        end
        check("b2b_end", busy_w, 0);
        clear_counts();
        din = 8'h3C;
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 70; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check("rst_tx", tx_w, 2'b11);
        check("rst_busy", busy_w, 0);
        check("rst_done", dcnt[0] + dcnt[1], 0);
        frame(8'h3C, 1, -1);
        check("busy3C_0", bobs[0], 16 * (NBITS - 1) + 16);
        check("busy3C_1", bobs[1], 16 * (NBITS - 1) + 24);
        check("par3C_0", par_w[0], 0);
        check("par3C_1", par_w[1], EN ? 1 : 0);
        for (int i = 0; i < 6; i++)
            frame(8'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1) ? 5 : -1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
